// File: rtl/fp21_pkg.sv
// Shared FP21 definitions: field widths/offsets, dot3 FSM encoding and a
// leading-zero counter for mantissa normalisation.
`ifndef FP_EXP
`define FP_EXP 6
`endif
`ifndef FP_FRAC
`define FP_FRAC 12
`endif

package fp21_pkg;

    localparam int FP_W     = `FP_EXP + `FP_FRAC + 3;
    localparam int EXP_W    = `FP_EXP + 1;
    localparam int FRAC_W   = `FP_FRAC + 1;
    localparam int MANT_W   = FRAC_W + 1;
    localparam int SIGN_POS = FP_W - 1;
    localparam int EXP_MSB  = FRAC_W + EXP_W - 1;
    localparam int EXP_LSB  = FRAC_W;
    localparam int FRAC_MSB = FRAC_W - 1;

    localparam logic [EXP_W-1:0] EXP_BIAS = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W-1:0] EXP_MAX  = {EXP_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_ADD0 = 3'd2,
        ST_ADD1 = 3'd3,
        ST_DONE = 3'd4
    } dot3_state_e;

    function automatic logic [4:0] lzc_mant(input logic [MANT_W-1:0] m);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            found = found | m[i];
            n     = n + {4'd0, ~found};
        end
        return n;
    endfunction

endpackage

// File: rtl/fp21_add.sv
// FP21 adder core: zero-exponent operand passes the other through, alignment
// truncates, exact cancellation gives +0, overflow saturates.
module FP21_add import fp21_pkg::*; #(
    parameter int LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] s
);

    logic                    a_ge_b_s;
    logic [FP_W-1:0]         lg_s;
    logic [FP_W-1:0]         sm_s;
    logic [EXP_W-1:0]        d_s;
    logic [MANT_W-1:0]       ml_s;
    logic [MANT_W-1:0]       ms_sh_s;
    logic [MANT_W:0]         sum_s;
    logic [MANT_W-1:0]       diff_s;
    logic [4:0]              lz_s;
    logic [MANT_W-1:0]       norm_s;
    logic [EXP_W:0]          e_sum_s;
    logic signed [EXP_W+1:0] e_diff_s;
    logic [FP_W-1:0]         res_s;
    logic [FP_W-1:0]         pipe_r [LAT];
    logic                    unused_s;

    assign unused_s = norm_s[MANT_W-1];

    // Order by magnitude, align the smaller operand, then add or subtract
    always_comb begin
        a_ge_b_s = a[FP_W-2:0] >= b[FP_W-2:0];
        lg_s     = a_ge_b_s ? a : b;
        sm_s     = a_ge_b_s ? b : a;
        d_s      = lg_s[EXP_MSB:EXP_LSB] - sm_s[EXP_MSB:EXP_LSB];
        ml_s     = {1'b1, lg_s[FRAC_MSB:0]};
        ms_sh_s  = {1'b1, sm_s[FRAC_MSB:0]} >> d_s;
        sum_s    = {1'b0, ml_s} + {1'b0, ms_sh_s};
        diff_s   = ml_s - ms_sh_s;
        lz_s     = lzc_mant(diff_s);
        norm_s   = diff_s << lz_s;
        e_sum_s  = {1'b0, lg_s[EXP_MSB:EXP_LSB]} + {{EXP_W{1'b0}}, sum_s[MANT_W]};
        e_diff_s = $signed({2'b00, lg_s[EXP_MSB:EXP_LSB]}) - $signed({4'b0000, lz_s});
        if (a[EXP_MSB:EXP_LSB] == '0) begin
            res_s = b;
        end else if (b[EXP_MSB:EXP_LSB] == '0) begin
            res_s = a;
        end else if (lg_s[SIGN_POS] == sm_s[SIGN_POS]) begin
            if (e_sum_s >= {1'b0, EXP_MAX}) begin
                res_s = {lg_s[SIGN_POS], EXP_MAX, {FRAC_W{1'b0}}};
            end else if (sum_s[MANT_W]) begin
                res_s = {lg_s[SIGN_POS], e_sum_s[EXP_W-1:0], sum_s[MANT_W-1 -: FRAC_W]};
            end else begin
                res_s = {lg_s[SIGN_POS], e_sum_s[EXP_W-1:0], sum_s[FRAC_W-1:0]};
            end
        end else if (diff_s == '0) begin
            res_s = '0;
        end else if (e_diff_s[EXP_W+1] || (e_diff_s == '0)) begin
            res_s = '0;
        end else if (e_diff_s[EXP_W:0] >= {1'b0, EXP_MAX}) begin
            res_s = {lg_s[SIGN_POS], EXP_MAX, {FRAC_W{1'b0}}};
        end else begin
            res_s = {lg_s[SIGN_POS], e_diff_s[EXP_W-1:0], norm_s[FRAC_W-1:0]};
        end
    end

    // Latency pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe_r[i] <= '0;
        end else begin
            pipe_r[0] <= res_s;
            for (int i = 1; i < LAT; i++) pipe_r[i] <= pipe_r[i-1];
        end
    end

    assign s = pipe_r[LAT-1];

endmodule

// File: rtl/fp21_mult.sv
// FP21 multiplier core: truncating, zero exponent flushes to +0, overflow
// saturates to the maximum exponent; result delayed by LAT registers.
module FP21_mult import fp21_pkg::*; #(
    parameter int LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] p
);

    logic                      sign_s;
    logic [MANT_W-1:0]         ma_s;
    logic [MANT_W-1:0]         mb_s;
    logic [2*MANT_W-1:0]       prod_s;
    logic signed [EXP_W+2:0]   e_s;
    logic [FP_W-1:0]           res_s;
    logic [FP_W-1:0]           pipe_r [LAT];
    logic                      unused_s;

    assign unused_s = ^prod_s[FRAC_W-1:0];

    // Combinational product with normalisation by at most one place
    always_comb begin
        sign_s = a[SIGN_POS] ^ b[SIGN_POS];
        ma_s   = {1'b1, a[FRAC_MSB:0]};
        mb_s   = {1'b1, b[FRAC_MSB:0]};
        prod_s = ma_s * mb_s;
        e_s    = $signed({3'b000, a[EXP_MSB:EXP_LSB]})
               + $signed({3'b000, b[EXP_MSB:EXP_LSB]})
               - $signed({3'b000, EXP_BIAS})
               + $signed({{(EXP_W+2){1'b0}}, prod_s[2*MANT_W-1]});
        if ((a[EXP_MSB:EXP_LSB] == '0) || (b[EXP_MSB:EXP_LSB] == '0)) begin
            res_s = '0;
        end else if (e_s[EXP_W+2] || (e_s == '0)) begin
            res_s = '0;
        end else if (e_s[EXP_W+1:0] >= {2'b00, EXP_MAX}) begin
            res_s = {sign_s, EXP_MAX, {FRAC_W{1'b0}}};
        end else if (prod_s[2*MANT_W-1]) begin
            res_s = {sign_s, e_s[EXP_W-1:0], prod_s[2*MANT_W-2 -: FRAC_W]};
        end else begin
            res_s = {sign_s, e_s[EXP_W-1:0], prod_s[2*MANT_W-3 -: FRAC_W]};
        end
    end

    // Latency pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe_r[i] <= '0;
        end else begin
            pipe_r[0] <= res_s;
            for (int i = 1; i < LAT; i++) pipe_r[i] <= pipe_r[i-1];
        end
    end

    assign p = pipe_r[LAT-1];

endmodule

// File: rtl/fp21_dot3_stage.sv
// Three-term FP21 dot product (ax*bx + ay*by) + az*bz using a single
// multiplier and a single adder, sequenced by a cycle counter.
module fp21_dot3_stage import fp21_pkg::*; #(
    parameter int MULT_LAT = 1,
    parameter int ADD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP_W-1:0]   in_a_x,
    input  logic [FP_W-1:0]   in_a_y,
    input  logic [FP_W-1:0]   in_a_z,
    input  logic [FP_W-1:0]   in_b_x,
    input  logic [FP_W-1:0]   in_b_y,
    input  logic [FP_W-1:0]   in_b_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_zero,
    output logic              busy
);

    // cnt_r = k during the k-th cycle after accept; these mark arrivals/issues
    localparam logic [7:0] CNT_PX     = 8'(MULT_LAT + 1);
    localparam logic [7:0] CNT_PZ     = 8'(MULT_LAT + 3);
    localparam logic [7:0] CNT_A0_END = 8'(MULT_LAT + 1 + ADD_LAT);
    localparam logic [7:0] CNT_S1     = 8'(MULT_LAT + 2 + 2 * ADD_LAT);

    dot3_state_e       state_r;
    dot3_state_e       state_nx_s;
    logic [7:0]        cnt_r;
    logic [7:0]        cnt_nx_s;
    logic              accept_s;
    logic              load_s;
    logic              release_s;

    logic [FP_W-1:0]   a_x_r, a_y_r, a_z_r, b_x_r, b_y_r, b_z_r;
    logic [FP_W-1:0]   px_r;
    logic [FP_W-1:0]   pz_r;
    logic [FP_W-1:0]   mul_a_s, mul_b_s, mul_res_s;
    logic [FP_W-1:0]   add_a_s, add_b_s, add_res_s;

    logic              out_valid_r;
    logic              out_sign_r;
    logic [EXP_W-1:0]  out_exp_r;
    logic [FRAC_W-1:0] out_frac_r;
    logic              out_zero_r;

    FP21_mult #(.LAT(MULT_LAT)) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (mul_a_s),
        .b     (mul_b_s),
        .p     (mul_res_s)
    );

    FP21_add #(.LAT(ADD_LAT)) u_add (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (add_a_s),
        .b     (add_b_s),
        .s     (add_res_s)
    );

    // Next-state and cycle counter
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        accept_s   = 1'b0;
        load_s     = 1'b0;
        release_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_MUL;
                    cnt_nx_s   = 8'd1;
                end else begin
                    cnt_nx_s   = 8'd0;
                end
            end
            ST_MUL: begin
                cnt_nx_s = cnt_r + 8'd1;
                if (cnt_r == CNT_PX) state_nx_s = ST_ADD0;
                else                 state_nx_s = ST_MUL;
            end
            ST_ADD0: begin
                cnt_nx_s = cnt_r + 8'd1;
                if (cnt_r == CNT_A0_END) state_nx_s = ST_ADD1;
                else                     state_nx_s = ST_ADD0;
            end
            ST_ADD1: begin
                if (cnt_r == CNT_S1) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_DONE;
                    cnt_nx_s   = 8'd0;
                end else begin
                    cnt_nx_s   = cnt_r + 8'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    release_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 8'd0;
            end
        endcase
    end

    // Operand steering into the shared cores; z stays on the multiplier past cycle 3
    always_comb begin
        case (cnt_r)
            8'd1: begin
                mul_a_s = a_x_r;
                mul_b_s = b_x_r;
            end
            8'd2: begin
                mul_a_s = a_y_r;
                mul_b_s = b_y_r;
            end
            default: begin
                mul_a_s = a_z_r;
                mul_b_s = b_z_r;
            end
        endcase
        if (state_r == ST_ADD1) begin
            add_a_s = add_res_s;
            add_b_s = (cnt_r == CNT_PZ) ? mul_res_s : pz_r;
        end else begin
            add_a_s = px_r;
            add_b_s = mul_res_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Operand capture on accept only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_x_r <= '0; a_y_r <= '0; a_z_r <= '0;
            b_x_r <= '0; b_y_r <= '0; b_z_r <= '0;
        end else if (accept_s) begin
            a_x_r <= in_a_x; a_y_r <= in_a_y; a_z_r <= in_a_z;
            b_x_r <= in_b_x; b_y_r <= in_b_y; b_z_r <= in_b_z;
        end else begin
            a_x_r <= a_x_r; a_y_r <= a_y_r; a_z_r <= a_z_r;
            b_x_r <= b_x_r; b_y_r <= b_y_r; b_z_r <= b_z_r;
        end
    end

    // Hold p_x until p_y arrives, and p_z until the second add issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_r <= '0;
            pz_r <= '0;
        end else begin
            px_r <= (cnt_r == CNT_PX) ? mul_res_s : px_r;
            pz_r <= (cnt_r == CNT_PZ) ? mul_res_s : pz_r;
        end
    end

    // Result registers, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_sign_r  <= 1'b0;
            out_exp_r   <= '0;
            out_frac_r  <= '0;
            out_zero_r  <= 1'b1;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_sign_r  <= add_res_s[SIGN_POS];
            out_exp_r   <= add_res_s[EXP_MSB:EXP_LSB];
            out_frac_r  <= add_res_s[FRAC_MSB:0];
            out_zero_r  <= (add_res_s[EXP_MSB:EXP_LSB] == '0);
        end else if (release_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign out_valid = out_valid_r;
    assign out_sign  = out_sign_r;
    assign out_exp   = out_exp_r;
    assign out_frac  = out_frac_r;
    assign out_zero  = out_zero_r;

endmodule

// File: tb/tb_fp21_dot3_stage.sv
// Directed table vectors, stall/busy/reset sequences and a random back-to-back
// run checked against an independent integer model of the FP21 cores.
module tb_fp21_dot3_stage;

    typedef logic [20:0] w_t;
    typedef struct {
        w_t   ax, ay, az, bx, by, bz;
        w_t   res;
        logic zero;
    } vec_t;

    localparam w_t F_0   = 21'h000000;
    localparam w_t F_1   = 21'h07E000;
    localparam w_t F_2   = 21'h080000;
    localparam w_t F_3   = 21'h081000;
    localparam w_t F_4   = 21'h082000;
    localparam w_t F_5   = 21'h082800;
    localparam w_t F_6   = 21'h083000;
    localparam w_t F_32  = 21'h088000;
    localparam w_t F_M1  = 21'h17E000;
    localparam w_t F_H   = 21'h07C000;
    localparam w_t F_M4  = 21'h182000;
    localparam int NRND  = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [20:0] in_a_x, in_a_y, in_a_z, in_b_x, in_b_y, in_b_z;
    logic        out_sign, out_zero, busy;
    logic [6:0]  out_exp;
    logic [12:0] out_frac;

    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tbl [5];
    vec_t junk_v;
    vec_t rv [NRND];
    w_t   res_w;
    logic res_z;
    int   lat;

    fp21_dot3_stage #(.MULT_LAT(1), .ADD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a_x(in_a_x), .in_a_y(in_a_y), .in_a_z(in_a_z),
        .in_b_x(in_b_x), .in_b_y(in_b_y), .in_b_z(in_b_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
        .out_exp(out_exp), .out_frac(out_frac), .out_zero(out_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    function automatic w_t m_mul(input w_t a, input w_t b);
        int ea, eb, ma, mb, pr, sh, e;
        logic s;
        ea = int'(a[19:13]); eb = int'(b[19:13]);
        if (ea == 0 || eb == 0) return 21'd0;
        ma = 8192 + int'(a[12:0]); mb = 8192 + int'(b[12:0]);
        pr = ma * mb;
        sh = (pr >= (1 << 27)) ? 1 : 0;
        e  = ea + eb - 63 + sh;
        s  = a[20] ^ b[20];
        if (e <= 0) return 21'd0;
        if (e >= 127) return {s, 7'd127, 13'd0};
        return {s, 7'(e), 13'((pr >> (13 + sh)) & 8191)};
    endfunction

    function automatic w_t m_add(input w_t a, input w_t b);
        w_t l, sm;
        int d, ml, ms, t, e;
        if (a[19:13] == 7'd0) return b;
        if (b[19:13] == 7'd0) return a;
        if (a[19:0] >= b[19:0]) begin l = a; sm = b; end
        else begin l = b; sm = a; end
        d  = int'(l[19:13]) - int'(sm[19:13]);
        ml = 8192 + int'(l[12:0]);
        ms = (d >= 14) ? 0 : ((8192 + int'(sm[12:0])) >> d);
        t  = (l[20] == sm[20]) ? ml + ms : ml - ms;
        if (t == 0) return 21'd0;
        e = int'(l[19:13]);
        while (t >= 16384) begin t = t >> 1; e++; end
        while (t < 8192) begin t = t << 1; e--; end
        if (e <= 0) return 21'd0;
        if (e >= 127) return {l[20], 7'd127, 13'd0};
        return {l[20], 7'(e), 13'(t & 8191)};
    endfunction

    function automatic w_t rnd_w();
        if ($urandom_range(0, 15) == 0) return 21'd0;
        return {1'($urandom_range(0, 1)), 7'($urandom_range(55, 70)), 13'($urandom_range(0, 8191))};
    endfunction

    task automatic drive(input vec_t v);
        in_a_x = v.ax; in_a_y = v.ay; in_a_z = v.az;
        in_b_x = v.bx; in_b_y = v.by; in_b_z = v.bz;
    endtask

    // Offer v, optionally keep offering junk_v while busy, stall the consumer, then release
    task automatic run_txn(input vec_t v, input int stall, input int junk,
                           output w_t res, output logic zr, output int l);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        drive(v);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        l = -1;
        do begin
            @(posedge clk); #1;
            l++;
            if (l < junk) begin drive(junk_v); in_valid = 1'b1; end
            else in_valid = 1'b0;
        end while (!out_valid && l < 40);
        check("out_valid_seen", 32'(out_valid), 32'd1);
        res = {out_sign, out_exp, out_frac};
        zr  = out_zero;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_hold", 32'({out_sign, out_exp, out_frac, out_zero}), 32'({res, zr}));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_pulse_end", 32'(out_valid), 32'd0);
        check("idle_after_done", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; out_ready = 1'b0;
        drive('{F_0, F_0, F_0, F_0, F_0, F_0, F_0, 1'b0});
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'({out_sign, out_exp, out_frac}), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        tbl[0] = '{F_1, F_2, F_3, F_4, F_5, F_6, F_32, 1'b0};
        tbl[1] = '{F_1, F_0, F_0, F_0, F_1, F_0, F_0, 1'b1};
        tbl[2] = '{F_M1, F_2, F_0, F_3, F_1, F_5, F_M1, 1'b0};
        tbl[3] = '{F_H, F_H, F_H, F_2, F_2, F_M4, F_0, 1'b1};
        tbl[4] = '{F_2, F_2, F_2, F_1, F_1, F_1, F_6, 1'b0};

        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i], 0, 0, res_w, res_z, lat);
            check($sformatf("vec%0d_result", i), 32'(res_w), 32'(tbl[i].res));
            check($sformatf("vec%0d_zero", i), 32'(res_z), 32'(tbl[i].zero));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
        end

        run_txn(tbl[0], 10, 0, res_w, res_z, lat);
        check("stall_result", 32'(res_w), 32'(F_32));

        junk_v = tbl[4];
        run_txn(tbl[0], 0, 4, res_w, res_z, lat);
        check("busy_ignore_result", 32'(res_w), 32'(F_32));
        check("busy_ignore_latency", 32'(lat), 32'd5);

        // Reset two edges after accept must kill the transaction
        drive(tbl[0]); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                seen = seen | out_valid;
            end
            check("midrst_no_valid", 32'(seen), 32'd0);
        end
        run_txn(tbl[4], 0, 0, res_w, res_z, lat);
        check("after_rst_result", 32'(res_w), 32'(F_6));
        check("after_rst_latency", 32'(lat), 32'd5);

        // Back-to-back random vectors with in_valid held high
        for (int i = 0; i < NRND; i++) begin
            rv[i].ax = rnd_w(); rv[i].ay = rnd_w(); rv[i].az = rnd_w();
            rv[i].bx = rnd_w(); rv[i].by = rnd_w(); rv[i].bz = rnd_w();
            rv[i].res = m_add(m_add(m_mul(rv[i].ax, rv[i].bx), m_mul(rv[i].ay, rv[i].by)),
                              m_mul(rv[i].az, rv[i].bz));
            rv[i].zero = (rv[i].res[19:13] == 7'd0);
        end
        begin
            int k_iss, k_done;
            logic acc;
            k_iss = 0; k_done = 0;
            out_ready = 1'b1;
            for (int cyc = 0; cyc < 2000 && k_done < NRND; cyc++) begin
                if (k_iss < NRND) begin drive(rv[k_iss]); in_valid = 1'b1; end
                else in_valid = 1'b0;
                acc = in_ready && (k_iss < NRND);
                @(posedge clk); #1;
                if (acc) k_iss++;
                if (out_valid) begin
                    check($sformatf("rnd%0d_result", k_done), 32'({out_sign, out_exp, out_frac}),
                          32'(rv[k_done].res));
                    check($sformatf("rnd%0d_zero", k_done), 32'(out_zero), 32'(rv[k_done].zero));
                    k_done++;
                end
            end
            in_valid = 1'b0;
            check("rnd_all_done", 32'(k_done), 32'(NRND));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
